// File: rtl/reg_ring_initiator_if.sv
// Local command/response channel plus ring head/tail bundle for the register ring initiator.
`ifndef UDP_REG_ADDR_WIDTH
`define UDP_REG_ADDR_WIDTH 23
`endif
`ifndef CPCI_NF2_DATA_WIDTH
`define CPCI_NF2_DATA_WIDTH 32
`endif

interface reg_ring_initiator_if;
  logic                            cmd_valid;
  logic                            cmd_ready;
  logic                            cmd_rd_wr_L;
  logic [`UDP_REG_ADDR_WIDTH-1:0]  cmd_addr;
  logic [`CPCI_NF2_DATA_WIDTH-1:0] cmd_wdata;

  logic                            rsp_valid;
  logic                            rsp_ready;
  logic [`CPCI_NF2_DATA_WIDTH-1:0] rsp_data;
  logic                            rsp_err;
  logic                            rsp_timeout;

  logic                            reg_req_out;
  logic                            reg_ack_out;
  logic                            reg_rd_wr_L_out;
  logic [`UDP_REG_ADDR_WIDTH-1:0]  reg_addr_out;
  logic [`CPCI_NF2_DATA_WIDTH-1:0] reg_data_out;
  logic [1:0]                      reg_src_out;

  logic                            reg_req_in;
  logic                            reg_ack_in;
  logic                            reg_rd_wr_L_in;
  logic [`UDP_REG_ADDR_WIDTH-1:0]  reg_addr_in;
  logic [`CPCI_NF2_DATA_WIDTH-1:0] reg_data_in;
  logic [1:0]                      reg_src_in;

  modport slave (
    input  cmd_valid, cmd_rd_wr_L, cmd_addr, cmd_wdata, rsp_ready,
           reg_req_in, reg_ack_in, reg_rd_wr_L_in, reg_addr_in, reg_data_in, reg_src_in,
    output cmd_ready, rsp_valid, rsp_data, rsp_err, rsp_timeout,
           reg_req_out, reg_ack_out, reg_rd_wr_L_out, reg_addr_out, reg_data_out, reg_src_out
  );

  modport master (
    output cmd_valid, cmd_rd_wr_L, cmd_addr, cmd_wdata, rsp_ready,
           reg_req_in, reg_ack_in, reg_rd_wr_L_in, reg_addr_in, reg_data_in, reg_src_in,
    input  cmd_ready, rsp_valid, rsp_data, rsp_err, rsp_timeout,
           reg_req_out, reg_ack_out, reg_rd_wr_L_out, reg_addr_out, reg_data_out, reg_src_out
  );
endinterface

// File: rtl/reg_ring_initiator.sv
// Single-outstanding register ring initiator: issues one ring request, waits for its
// tagged return or a timeout, then holds the response until the consumer takes it.
module reg_ring_initiator #(
  parameter logic [1:0] SRC_ID  = 2'b00,
  parameter int         TIMEOUT = 255
) (
  input  logic                 clk,
  input  logic                 reset,
  reg_ring_initiator_if.slave  bus,
  output logic [15:0]          stray_cnt
);
  localparam int AW = `UDP_REG_ADDR_WIDTH;
  localparam int DW = `CPCI_NF2_DATA_WIDTH;
  localparam logic [DW-1:0] ERR_DATA = DW'(32'hDEAD_BEEF);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  state_t state, state_nxt;

  logic          rd_wr_L_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic [15:0]   tmo_cnt;
  logic [DW-1:0] rsp_data_q;
  logic          rsp_err_q, rsp_tmo_q;
  logic          match, tmo_hit;
  logic          unused_ok;

  assign unused_ok = bus.reg_rd_wr_L_in;

  assign match   = bus.reg_req_in && (bus.reg_src_in == SRC_ID) && (bus.reg_addr_in == addr_q);
  // tmo_cnt counts completed WAIT cycles, so this is the TIMEOUT-th one
  assign tmo_hit = (tmo_cnt == 16'(TIMEOUT - 1));

  always_comb begin
    state_nxt           = state;
    bus.cmd_ready       = (state == IDLE);
    bus.rsp_valid       = (state == RESP);
    bus.rsp_data        = rsp_data_q;
    bus.rsp_err         = rsp_err_q;
    bus.rsp_timeout     = rsp_tmo_q;
    bus.reg_req_out     = 1'b0;
    bus.reg_ack_out     = 1'b0;
    bus.reg_rd_wr_L_out = 1'b1;
    bus.reg_addr_out    = '0;
    bus.reg_data_out    = '0;
    bus.reg_src_out     = 2'b00;
    case (state)
      IDLE:  if (bus.cmd_valid) state_nxt = ISSUE;
      ISSUE: begin
        bus.reg_req_out     = 1'b1;
        bus.reg_rd_wr_L_out = rd_wr_L_q;
        bus.reg_addr_out    = addr_q;
        bus.reg_data_out    = wdata_q;
        bus.reg_src_out     = SRC_ID;
        state_nxt           = WAIT;
      end
      WAIT:  if (match || tmo_hit) state_nxt = RESP;
      RESP:  if (bus.rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      rd_wr_L_q  <= 1'b1;
      addr_q     <= '0;
      wdata_q    <= '0;
      tmo_cnt    <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
      rsp_tmo_q  <= 1'b0;
      stray_cnt  <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && bus.cmd_valid) begin
        rd_wr_L_q <= bus.cmd_rd_wr_L;
        addr_q    <= bus.cmd_addr;
        wdata_q   <= bus.cmd_wdata;
      end
      if (state == ISSUE)     tmo_cnt <= '0;
      else if (state == WAIT) tmo_cnt <= tmo_cnt + 16'd1;
      // a matching return beats a simultaneous timeout
      if (state == WAIT) begin
        if (match) begin
          rsp_err_q  <= !bus.reg_ack_in;
          rsp_tmo_q  <= 1'b0;
          rsp_data_q <= !bus.reg_ack_in ? ERR_DATA : (rd_wr_L_q ? bus.reg_data_in : wdata_q);
        end else if (tmo_hit) begin
          rsp_err_q  <= 1'b1;
          rsp_tmo_q  <= 1'b1;
          rsp_data_q <= ERR_DATA;
        end
      end
      if (bus.reg_req_in && !(state == WAIT && match) && stray_cnt != 16'hFFFF)
        stray_cnt <= stray_cnt + 16'd1;
    end
  end
endmodule
